// File: rtl/lab3_nibble_serial_sub.sv
// Multi-precision subtractor: Diff = X - Y - Bin, one 4-bit ripple-borrow slice per clock,
// least-significant nibble first, with the slice borrow registered between cycles.
module lab3_nibble_serial_sub #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   X,
  input  logic [4*NIBBLES-1:0]   Y,
  input  logic                   Bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   Diff,
  output logic                   Bout
);

  localparam int W = 4 * NIBBLES;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   xs_q, xs_d;
  logic [W-1:0]   ys_q, ys_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           borrow_q, borrow_d;
  logic           bout_q, bout_d;
  logic           done_q, done_d;
  logic [4:0]     cnt_q, cnt_d;

  logic [4:0]     stage;
  logic [3:0]     stageDiff;
  logic           stageBorrow;
  logic [W-1:0]   xsShift;
  logic [W-1:0]   ysShift;
  logic           lastNibble;

  // The 4-bit stage: a 5-bit difference whose top bit is the borrow-out.
  always_comb begin
    stage       = {1'b0, xs_q[3:0]} - {1'b0, ys_q[3:0]} - {4'b0000, borrow_q};
    stageDiff   = stage[3:0];
    stageBorrow = stage[4];
  end

  // The minuend register doubles as the result register: each slice result enters at the
  // top as the consumed nibble leaves the bottom, so after NIBBLES shifts it holds Diff.
  generate
    if (NIBBLES == 1) begin : gSingle
      assign xsShift = stageDiff;
      assign ysShift = '0;
    end else begin : gMulti
      assign xsShift = {stageDiff, xs_q[W-1:4]};
      assign ysShift = {4'b0000, ys_q[W-1:4]};
    end
  endgenerate

  assign lastNibble = (cnt_q == 5'(NIBBLES - 1));

  always_comb begin
    state_d  = state_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          xs_d     = X;
          ys_d     = Y;
          borrow_d = Bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        xs_d     = xsShift;
        ys_d     = ysShift;
        borrow_d = stageBorrow;
        cnt_d    = cnt_q + 5'd1;
        if (lastNibble) begin
          state_d = DONE;
          diff_d  = xsShift;
          bout_d  = stageBorrow;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      xs_q     <= '0;
      ys_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule
